// File: rtl/cmd_mreq_dec.sv
// Host byte-stream header parser producing mreq descriptors for cmd_wb, with write-payload passthrough.
// Optional inter-byte header timeout: define CMD_MREQ_DEC_TIMEOUT_EN.
module cmd_mreq_dec #(
  parameter logic [7:0]  MAGIC          = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  localparam int         MREQ_NBIT      = 45
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  output logic                 o_rx_ready,
  output logic                 o_mreq_valid,
  input  logic                 i_mreq_ready,
  output logic [MREQ_NBIT-1:0] o_mreq,
  output logic [7:0]           o_pl_data,
  output logic                 o_pl_valid,
  input  logic                 i_pl_ready,
  output logic                 o_busy,
  output logic [7:0]           o_err_cnt
);

  // Descriptor layout: {tag[7:0], wr, aincr, wfmt[2:0], wcnt[7:0], addr[23:0]}
  function automatic logic [MREQ_NBIT-1:0] pack_mreq(
    input logic [7:0]  tag,
    input logic        wr,
    input logic        aincr,
    input logic [2:0]  wfmt,
    input logic [7:0]  wcnt,
    input logic [23:0] addr
  );
    return {tag, wr, aincr, wfmt, wcnt, addr};
  endfunction

  typedef enum logic [2:0] {
    S_SYNC, S_TAG, S_FLAGS, S_WCNT, S_A2, S_A1, S_A0, S_EXEC
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must fit the 16-bit idle counter");
  end

  state_t                 state_q;
  logic [7:0]             tag_q, wcnt_q, a2_q, a1_q, err_q, err_d;
  logic                   wr_q, aincr_q;
  logic [2:0]             wfmt_q;
  logic [MREQ_NBIT-1:0]   mreq_q;
  logic                   mreq_valid_q;
  logic                   rx_ready, pl_valid, rx_acc, tmo_hit;

  assign err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

  // Header states always accept; EXEC either forwards payload or holds the host off.
  always_comb begin
    rx_ready = 1'b1;
    pl_valid = 1'b0;
    if (state_q == S_EXEC) begin
      rx_ready = wr_q & i_pl_ready;
      pl_valid = wr_q & i_rx_valid;
    end
  end

  assign rx_acc = i_rx_valid & rx_ready;

`ifdef CMD_MREQ_DEC_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_q;
  logic        in_hdr;

  assign in_hdr  = (state_q != S_SYNC) && (state_q != S_EXEC);
  assign tmo_hit = in_hdr && !rx_acc && (tmo_q == TMO_LAST);

  // Counts idle cycles since the last accepted header byte.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                 tmo_q <= '0;
    else if (!in_hdr || rx_acc) tmo_q <= '0;
    else                       tmo_q <= tmo_q + 16'd1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_SYNC;
      tag_q        <= '0;
      wr_q         <= 1'b0;
      aincr_q      <= 1'b0;
      wfmt_q       <= '0;
      wcnt_q       <= '0;
      a2_q         <= '0;
      a1_q         <= '0;
      mreq_q       <= '0;
      mreq_valid_q <= 1'b0;
      err_q        <= '0;
    end else if (tmo_hit) begin
      state_q <= S_SYNC;
      err_q   <= err_d;
    end else begin
      case (state_q)
        S_SYNC:  if (rx_acc && i_rx_data == MAGIC) state_q <= S_TAG;
        S_TAG:   if (rx_acc) begin
          tag_q   <= i_rx_data;
          state_q <= S_FLAGS;
        end
        S_FLAGS: if (rx_acc) begin
          if (i_rx_data[5:3] != 3'b000) begin
            err_q   <= err_d;
            state_q <= S_SYNC;
          end else begin
            wr_q    <= i_rx_data[7];
            aincr_q <= i_rx_data[6];
            wfmt_q  <= i_rx_data[2:0];
            state_q <= S_WCNT;
          end
        end
        S_WCNT:  if (rx_acc) begin
          wcnt_q  <= i_rx_data;
          state_q <= S_A2;
        end
        S_A2:    if (rx_acc) begin
          a2_q    <= i_rx_data;
          state_q <= S_A1;
        end
        S_A1:    if (rx_acc) begin
          a1_q    <= i_rx_data;
          state_q <= S_A0;
        end
        S_A0:    if (rx_acc) begin
          mreq_q       <= pack_mreq(tag_q, wr_q, aincr_q, wfmt_q, wcnt_q,
                                    {a2_q, a1_q, i_rx_data});
          mreq_valid_q <= 1'b1;
          state_q      <= S_EXEC;
        end
        S_EXEC:  if (i_mreq_ready) begin
          mreq_valid_q <= 1'b0;
          state_q      <= S_SYNC;
        end
        default: state_q <= S_SYNC;
      endcase
    end
  end

  assign o_rx_ready   = rx_ready;
  assign o_pl_data    = i_rx_data;
  assign o_pl_valid   = pl_valid;
  assign o_mreq       = mreq_q;
  assign o_mreq_valid = mreq_valid_q;
  assign o_busy       = (state_q != S_SYNC);
  assign o_err_cnt    = err_q;

endmodule

// File: tb/tb_cmd_mreq_dec.sv
// Scoreboard bench for cmd_mreq_dec: expected descriptors and payload bytes are queued at drive time.
module tb_cmd_mreq_dec;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic        mreq_valid, mreq_ready;
  logic [44:0] mreq;
  logic [7:0]  pl_data;
  logic        pl_valid, pl_ready;
  logic        busy;
  logic [7:0]  err_cnt;
  logic        tog_en = 1'b0;
  logic        tog_q  = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) tog_q <= ~tog_q;
  assign pl_ready = tog_en ? tog_q : 1'b1;

  cmd_mreq_dec #(.MAGIC(8'hA5), .TIMEOUT_CYCLES(20)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
    .o_mreq_valid(mreq_valid), .i_mreq_ready(mreq_ready), .o_mreq(mreq),
    .o_pl_data(pl_data), .o_pl_valid(pl_valid), .i_pl_ready(pl_ready),
    .o_busy(busy), .o_err_cnt(err_cnt)
  );

  typedef struct packed {
    logic [7:0]  tag;
    logic        wr;
    logic        aincr;
    logic [2:0]  wfmt;
    logic [7:0]  wcnt;
    logic [23:0] addr;
  } mreq_t;

  mreq_t      exp_q[$];
  logic [7:0] pl_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic mreq_t mk(input logic [7:0] tag, input logic [7:0] flags,
                               input logic [7:0] wcnt, input logic [23:0] addr);
    mreq_t m;
    m.tag = tag; m.wr = flags[7]; m.aincr = flags[6]; m.wfmt = flags[2:0];
    m.wcnt = wcnt; m.addr = addr;
    return m;
  endfunction

  // Output monitor: pops expectations as the DUT presents descriptors and payload.
  logic        seen = 1'b0;
  logic [44:0] cap;
  mreq_t       mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (mreq_valid) begin
        if (!seen) begin
          if (exp_q.size() == 0) chk("mreq_unexp", 1, 0);
          else begin
            mon_e = exp_q.pop_front();
            chk("mreq_tag",   mreq[44:37], mon_e.tag);
            chk("mreq_wr",    mreq[36],    mon_e.wr);
            chk("mreq_aincr", mreq[35],    mon_e.aincr);
            chk("mreq_wfmt",  mreq[34:32], mon_e.wfmt);
            chk("mreq_wcnt",  mreq[31:24], mon_e.wcnt);
            chk("mreq_addr",  mreq[23:0],  mon_e.addr);
          end
          seen = 1'b1;
          cap  = mreq;
        end else chk("mreq_stable", mreq, cap);
      end else seen = 1'b0;
      if (pl_valid && pl_ready) begin
        if (pl_q.size() == 0) chk("pl_unexp", 1, 0);
        else chk("pl_data", pl_data, pl_q.pop_front());
      end
      if (!busy) chk("pl_idle", pl_valid, 0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int cyc = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    if (!rx_ready) chk("rx_stall", 0, 1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] tag, input logic [7:0] flags,
                            input logic [7:0] wcnt, input logic [23:0] addr);
    send_byte(8'hA5);
    send_byte(tag);
    send_byte(flags);
    if (flags[5:3] != 3'b000) return;
    exp_q.push_back(mk(tag, flags, wcnt, addr));
    send_byte(wcnt);
    send_byte(addr[23:16]);
    send_byte(addr[15:8]);
    chk("vld_early", mreq_valid, 0);
    send_byte(addr[7:0]);
    chk("vld_lat", mreq_valid, 1);
    chk("busy_exec", busy, 1);
  endtask

  task automatic finish_req();
    mreq_ready = 1'b1;
    tick();
    mreq_ready = 1'b0;
    chk("vld_drop", mreq_valid, 0);
    chk("busy_drop", busy, 0);
  endtask

  initial begin
    #400000;
    chk("watchdog", 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; mreq_ready = 1'b0;
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_vld",  mreq_valid, 0);
    chk("rst_mreq", mreq, 0);
    chk("rst_err",  err_cnt, 0);
    rst = 1'b0;
    tick();

    // Write frame, then payload with toggling pl_ready; last byte shares the handshake cycle.
    send_frame(8'hAA, 8'hC2, 8'h03, 24'h000003);
    tog_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pl_q.push_back(8'h10 + 8'(i));
      send_byte(8'h10 + 8'(i));
    end
    tog_en = 1'b0;
    pl_q.push_back(8'h13);
    rx_data = 8'h13; rx_valid = 1'b1; mreq_ready = 1'b1;
    @(negedge clk);
    chk("hs_rx_rdy", rx_ready, 1);
    tick();
    rx_valid = 1'b0; mreq_ready = 1'b0;
    chk("hs_vld_drop", mreq_valid, 0);
    chk("hs_busy", busy, 0);
    chk("pl_drain", pl_q.size(), 0);

    // Read frame: host byte held off until the handshake, then dropped in sync.
    send_frame(8'hCC, 8'h40, 8'h0F, 24'h000000);
    rx_data = 8'h55; rx_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rd_rx_rdy", rx_ready, 0);
      chk("rd_pl_vld", pl_valid, 0);
    end
    @(posedge clk); #1;
    mreq_ready = 1'b1;
    @(negedge clk);
    chk("rd_hs_rdy", rx_ready, 0);
    @(posedge clk); #1;
    mreq_ready = 1'b0;
    chk("rd_vld_drop", mreq_valid, 0);
    @(negedge clk);
    chk("sync_rdy", rx_ready, 1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    chk("err_55", err_cnt, 0);
    chk("busy_55", busy, 0);

    // Garbage before sync is silent; reserved flag bits count an error.
    send_byte(8'h00);
    send_byte(8'hFF);
    chk("junk_busy", busy, 0);
    chk("junk_err", err_cnt, 0);
    send_frame(8'h01, 8'h08, 8'h00, 24'h0);
    chk("rsv_err", err_cnt, 1);
    chk("rsv_busy", busy, 0);
    chk("rsv_vld", mreq_valid, 0);

    // Asynchronous reset mid-header.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'hC0);
    chk("mid_busy", busy, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_vld", mreq_valid, 0);
    chk("arst_err", err_cnt, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    send_frame(8'h5A, 8'h87, 8'hFF, 24'hABCDEF);
    finish_req();

    // Stalled header: times out only when the feature is built in.
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (25) tick();
`ifdef CMD_MREQ_DEC_TIMEOUT_EN
    chk("tmo_err", err_cnt, 1);
    chk("tmo_busy", busy, 0);
    send_frame(8'h02, 8'h00, 8'h01, 24'h123456);
    finish_req();
`else
    chk("stall_err", err_cnt, 0);
    chk("stall_busy", busy, 1);
    exp_q.push_back(mk(8'h01, 8'hC0, 8'h03, 24'h000003));
    send_byte(8'hC0);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h03);
    chk("stall_vld", mreq_valid, 1);
    finish_req();
`endif

    // Error counter saturation.
    for (int i = 0; i < 260; i++) send_frame(8'h00, 8'h38, 8'h00, 24'h0);
    chk("err_sat", err_cnt, 8'hFF);
    chk("sat_busy", busy, 0);
    chk("exp_drain", exp_q.size(), 0);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
